// File: rtl/input_queue_pkg.sv
// Shared definitions for the overlapping-frame input queue.
// Holds the read-side FSM state encoding, the default parameter values and
// the helper that turns an entry count into a pointer width.
package input_queue_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIME   = 2'd1,
        STREAM  = 2'd2,
        ADVANCE = 2'd3
    } queueState_e;

    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_FRAME_LEN  = 1024;
    localparam int DEF_HOP        = 512;
    localparam int DEF_DEPTH      = 4096;

    // Bits needed to address 'entries' locations (at least one bit).
    function automatic int ptrBits(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/overlap_addr_gen.sv
// Pointer, occupancy and frame-sequencing logic for the input queue.
// Ports:
//   clock, reset         - rising-edge clock, async active-high reset
//   adcValid_i           - incoming sample strobe
//   overflowClear_i      - clears the sticky overflow flag
//   readCredit_i         - output stage can accept one more RAM read
//   lastHandshake_i      - final sample of the current frame was consumed
//   wrEn_o / wrAddr_o    - RAM write port
//   rdEn_o / rdAddr_o    - RAM read port, rdLast_o marks the frame's last read
//   occupancy_o          - wrPtr minus frameStart, one extra bit
//   overflow_o           - sticky drop indicator
module overlap_addr_gen
    import input_queue_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int HOP       = DEF_HOP,
    parameter int DEPTH     = DEF_DEPTH,
    localparam int AW       = ptrBits(DEPTH),
    localparam int IW       = ptrBits(FRAME_LEN) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          adcValid_i,
    input  logic          overflowClear_i,
    input  logic          readCredit_i,
    input  logic          lastHandshake_i,
    output logic          wrEn_o,
    output logic [AW-1:0] wrAddr_o,
    output logic          rdEn_o,
    output logic [AW-1:0] rdAddr_o,
    output logic          rdLast_o,
    output logic [AW:0]   occupancy_o,
    output logic          overflow_o
);

    localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   FRAME_V  = (AW+1)'(FRAME_LEN);
    localparam logic [AW:0]   HOP_V    = (AW+1)'(HOP);
    localparam logic [AW-1:0] HOP_A    = AW'(HOP);
    localparam logic [IW-1:0] FRAME_I  = IW'(FRAME_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    queueState_e   state_q;
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] frameStart_q;
    logic [AW-1:0] frameStart_d;
    logic [AW-1:0] rdPtr_q;
    logic [IW-1:0] idx_q;
    logic [AW:0]   occ_q;
    logic [AW:0]   occ_d;
    logic          overflow_q;
    logic          overflow_d;
    logic          full;
    logic          drop;
    logic          advance;
    logic          frameReady;

    assign full        = (occ_q == DEPTH_V);
    assign wrEn_o      = adcValid_i && !full;
    assign drop        = adcValid_i && full;
    assign advance     = (state_q == ADVANCE);
    assign wrAddr_o    = wrPtr_q;
    assign rdAddr_o    = rdPtr_q;
    assign rdLast_o    = (idx_q == LAST_IDX);
    assign occupancy_o = occ_q;
    assign overflow_o  = overflow_q;

    // idx counts reads issued for the current frame; issuing stops once the
    // whole frame is in flight and only resumes for the next frame.
    assign rdEn_o = ((state_q == PRIME) || (state_q == STREAM)) &&
                    (idx_q != FRAME_I) && readCredit_i;

    // Next occupancy folds a same-cycle write and frame advance together, so
    // the start decisions below see the value the registers are about to hold.
    always_comb begin
        occ_d        = occ_q;
        frameStart_d = frameStart_q;
        if (wrEn_o) begin
            occ_d = occ_d + (AW+1)'(1);
        end
        if (advance) begin
            occ_d        = occ_d - HOP_V;
            frameStart_d = frameStart_q + HOP_A;
        end
    end

    assign frameReady = (occ_d >= FRAME_V);

    // A drop in the same cycle as a clear keeps the flag set.
    assign overflow_d = drop ? 1'b1 : (overflowClear_i ? 1'b0 : overflow_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wrPtr_q      <= '0;
            frameStart_q <= '0;
            rdPtr_q      <= '0;
            idx_q        <= '0;
            occ_q        <= '0;
            overflow_q   <= 1'b0;
        end else begin
            occ_q        <= occ_d;
            frameStart_q <= frameStart_d;
            overflow_q   <= overflow_d;
            if (wrEn_o) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (rdEn_o) begin
                rdPtr_q <= rdPtr_q + AW'(1);
                idx_q   <= idx_q + IW'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (frameReady) begin
                        state_q <= PRIME;
                        rdPtr_q <= frameStart_q;
                        idx_q   <= '0;
                    end
                end
                PRIME: begin
                    state_q <= STREAM;
                end
                STREAM: begin
                    if (lastHandshake_i) begin
                        state_q <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (frameReady) begin
                        state_q <= PRIME;
                        rdPtr_q <= frameStart_d;
                        idx_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/overlap_input_queue.sv
// Circular sample buffer that emits overlapping frames on an AXI-Stream port.
// Ports:
//   clock, reset              - rising-edge clock, async active-high reset
//   adc_sample, adc_valid     - sampler input, one strobe per sample
//   overflow_clear            - clears the sticky overflow flag
//   m_data, m_valid, m_ready  - AXI-Stream output, m_last on each frame end
//   overflow                  - sticky, a sample was dropped while full
//   occupancy                 - samples held from the current frame start
module overlap_input_queue
    import input_queue_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int HOP        = DEF_HOP,
    parameter int DEPTH      = DEF_DEPTH,
    localparam int AW        = ptrBits(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] adc_sample,
    input  logic                  adc_valid,
    input  logic                  overflow_clear,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  overflow,
    output logic [AW:0]           occupancy
);

    logic                  wrEn;
    logic [AW-1:0]         wrAddr;
    logic                  rdEn;
    logic [AW-1:0]         rdAddr;
    logic                  rdLast;
    logic                  readCredit;
    logic                  pop;
    logic                  lastHandshake;
    logic [1:0]            heldNext;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdData_q;
    logic                  rdValid_q;
    logic                  rdLast_q;

    logic [DATA_WIDTH-1:0] mData_q, mData_d;
    logic                  mValid_q, mValid_d;
    logic                  mLast_q, mLast_d;
    logic [DATA_WIDTH-1:0] sData_q, sData_d;
    logic                  sValid_q, sValid_d;
    logic                  sLast_q, sLast_d;

    overlap_addr_gen #(
        .FRAME_LEN (FRAME_LEN),
        .HOP       (HOP),
        .DEPTH     (DEPTH)
    ) addrGen (
        .clock           (clock),
        .reset           (reset),
        .adcValid_i      (adc_valid),
        .overflowClear_i (overflow_clear),
        .readCredit_i    (readCredit),
        .lastHandshake_i (lastHandshake),
        .wrEn_o          (wrEn),
        .wrAddr_o        (wrAddr),
        .rdEn_o          (rdEn),
        .rdAddr_o        (rdAddr),
        .rdLast_o        (rdLast),
        .occupancy_o     (occupancy),
        .overflow_o      (overflow)
    );

    assign pop           = mValid_q && m_ready;
    assign lastHandshake = pop && mLast_q;

    // A read issued now lands next cycle; only issue if the two output
    // entries plus the read already in flight leave a free slot after pop.
    assign heldNext   = 2'(mValid_q) + 2'(sValid_q) + 2'(rdValid_q) - 2'(pop);
    assign readCredit = (heldNext < 2'd2);

    // Simple dual-port array with a registered read, left unreset.
    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[wrAddr] <= adc_sample;
        end
        if (rdEn) begin
            rdData_q <= mem[rdAddr];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdValid_q <= 1'b0;
            rdLast_q  <= 1'b0;
        end else begin
            rdValid_q <= rdEn;
            rdLast_q  <= rdEn && rdLast;
        end
    end

    // Skid stage: the main register feeds the port, the skid register catches
    // a RAM word that arrives while the consumer stalls.
    always_comb begin
        mData_d  = mData_q;
        mValid_d = mValid_q;
        mLast_d  = mLast_q;
        sData_d  = sData_q;
        sValid_d = sValid_q;
        sLast_d  = sLast_q;
        if (!mValid_q || pop) begin
            if (sValid_q) begin
                mData_d  = sData_q;
                mValid_d = 1'b1;
                mLast_d  = sLast_q;
                sData_d  = rdData_q;
                sValid_d = rdValid_q;
                sLast_d  = rdLast_q;
            end else begin
                mData_d  = rdData_q;
                mValid_d = rdValid_q;
                mLast_d  = rdLast_q;
            end
        end else if (rdValid_q) begin
            sData_d  = rdData_q;
            sValid_d = 1'b1;
            sLast_d  = rdLast_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mValid_q <= 1'b0;
            mLast_q  <= 1'b0;
            sValid_q <= 1'b0;
            sLast_q  <= 1'b0;
        end else begin
            mValid_q <= mValid_d;
            mLast_q  <= mLast_d;
            sValid_q <= sValid_d;
            sLast_q  <= sLast_d;
        end
    end

    always_ff @(posedge clock) begin
        mData_q <= mData_d;
        sData_q <= sData_d;
    end

    assign m_data  = mData_q;
    assign m_valid = mValid_q;
    assign m_last  = mLast_q;

endmodule

// File: tb/tb_overlap_input_queue.sv
// Self-checking bench for overlap_input_queue with FRAME_LEN=8, HOP=4,
// DEPTH=32. A scoreboard of accepted samples predicts every output word as
// sample[n*HOP+k] for frame n, index k.
module tb_overlap_input_queue;

    localparam int DW = 12;
    localparam int FL = 8;
    localparam int HP = 4;
    localparam int DP = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] adc_sample = '0;
    logic          adc_valid = 1'b0;
    logic          overflow_clear = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          overflow;
    logic [5:0]    occupancy;

    overlap_input_queue #(
        .DATA_WIDTH (DW),
        .FRAME_LEN  (FL),
        .HOP        (HP),
        .DEPTH      (DP)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .adc_sample     (adc_sample),
        .adc_valid      (adc_valid),
        .overflow_clear (overflow_clear),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .overflow       (overflow),
        .occupancy      (occupancy)
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            failures = 0;
    int            sent[$];
    int            outIdx = 0;
    int            readyMode = 0;
    logic          holdPending = 1'b0;
    logic [DW-1:0] holdData;
    logic          holdLast;

    typedef struct {
        logic valid;
        int   sample;
        logic ready;
        logic expValid;
        int   expData;
        logic expLast;
        int   expOcc;
    } vec_t;

    vec_t vecs[20];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int modelOcc();
        return sent.size() - (outIdx / FL) * HP;
    endfunction

    function automatic int framesFor(input int n);
        return (n >= FL) ? ((n - FL) / HP + 1) : 0;
    endfunction

    // One clock of stimulus; the model accepts a sample unless the buffer is full.
    task automatic applyStimulus(input logic valid, input int sample, input logic clr);
        @(posedge clock);
        #1;
        adc_valid      = valid;
        adc_sample     = DW'(sample);
        overflow_clear = clr;
        if (readyMode == 0)      m_ready = 1'b0;
        else if (readyMode == 1) m_ready = 1'b1;
        else                     m_ready = ($urandom_range(0, 99) < 30);
        if (valid && (modelOcc() < DP)) sent.push_back(sample % 4096);
    endtask

    task automatic resetDut();
        @(posedge clock);
        #1;
        reset          = 1'b1;
        adc_valid      = 1'b0;
        overflow_clear = 1'b0;
        m_ready        = 1'b0;
        sent.delete();
        outIdx      = 0;
        holdPending = 1'b0;
        #2;
        checkOutput("rstValid", m_valid, 0);
        checkOutput("rstLast", m_last, 0);
        checkOutput("rstOvf", overflow, 0);
        checkOutput("rstOcc", occupancy, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Bounded wait for the model's frame count, then confirm the DUT goes quiet.
    task automatic waitOutputs(input int target, input int budget, input string name);
        int cycles = 0;
        while (outIdx < target && cycles < budget) begin
            applyStimulus(1'b0, 0, 1'b0);
            cycles++;
        end
        checkOutput({name, "Count"}, outIdx, target);
        repeat (6) applyStimulus(1'b0, 0, 1'b0);
        checkOutput({name, "Idle"}, m_valid, 0);
        checkOutput({name, "Occ"}, occupancy, sent.size() - framesFor(sent.size()) * HP);
    endtask

    // Stream monitor: every handshake against the scoreboard, every stall held.
    initial begin
        int n;
        int k;
        forever begin
            @(negedge clock);
            if (reset) begin
                holdPending = 1'b0;
            end else begin
                if (holdPending) begin
                    checkOutput("holdValid", m_valid, 1);
                    checkOutput("holdData", m_data, holdData);
                    checkOutput("holdLast", m_last, holdLast);
                    holdPending = 1'b0;
                end
                if (m_valid && m_ready) begin
                    n = outIdx / FL;
                    k = outIdx % FL;
                    if (n * HP + k < sent.size()) begin
                        checkOutput("streamData", m_data, sent[n * HP + k]);
                    end else begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL streamBeyond: got data %0d at output %0d, model has %0d samples",
                                 m_data, outIdx, sent.size());
                    end
                    checkOutput("streamLast", m_last, (k == FL - 1) ? 1 : 0);
                    outIdx++;
                end else if (m_valid) begin
                    holdPending = 1'b1;
                    holdData    = m_data;
                    holdLast    = m_last;
                end
            end
        end
    end

    initial begin
        int polls;

        // Single frame timing: 8 writes, output 2 cycles after the 8th write.
        for (int r = 0; r < 20; r++) begin
            vecs[r].valid    = (r < 8);
            vecs[r].sample   = r;
            vecs[r].ready    = 1'b1;
            vecs[r].expValid = (r >= 10 && r <= 17);
            vecs[r].expData  = r - 10;
            vecs[r].expLast  = (r == 17);
            vecs[r].expOcc   = (r <= 8) ? r : ((r <= 18) ? 8 : 4);
        end
        resetDut();
        for (int r = 0; r < 20; r++) begin
            readyMode = vecs[r].ready ? 1 : 0;
            applyStimulus(vecs[r].valid, vecs[r].sample, 1'b0);
            @(negedge clock);
            checkOutput($sformatf("vecValid%0d", r), m_valid, vecs[r].expValid);
            if (vecs[r].expValid) begin
                checkOutput($sformatf("vecData%0d", r), m_data, vecs[r].expData);
                checkOutput($sformatf("vecLast%0d", r), m_last, vecs[r].expLast);
            end
            checkOutput($sformatf("vecOcc%0d", r), occupancy, vecs[r].expOcc);
        end
        waitOutputs(8, 50, "first");

        // Continuous ramp with full ready: four overlapping frames.
        resetDut();
        readyMode = 1;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, i, 1'b0);
        waitOutputs(framesFor(sent.size()) * FL, 500, "ramp");

        // Same ramp with 30% ready: identical frame sequence, stalls held.
        resetDut();
        readyMode = 2;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, i, 1'b0);
        waitOutputs(framesFor(sent.size()) * FL, 2000, "stall");

        // Random values with random gaps and random ready.
        resetDut();
        readyMode = 2;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, int'($urandom_range(0, 4095)), 1'b0);
            repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 0, 1'b0);
        end
        waitOutputs(framesFor(sent.size()) * FL, 2000, "rand");

        // Fill to capacity with the consumer stalled, then overflow handling.
        resetDut();
        readyMode = 0;
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 512 + i, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("fullOcc", occupancy, 32);
        checkOutput("fullNoOvf", overflow, 0);
        applyStimulus(1'b1, 999, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("dropOcc", occupancy, 32);
        checkOutput("dropOvf", overflow, 1);
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("clearOvf", overflow, 0);
        applyStimulus(1'b1, 998, 1'b1);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("setWinsOvf", overflow, 1);
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("clear2Ovf", overflow, 0);
        checkOutput("ovfModelSize", sent.size(), modelOcc());
        readyMode = 1;
        waitOutputs(framesFor(sent.size()) * FL, 2000, "ovf");

        // 100 samples, wrapping the 32-entry buffer several times.
        resetDut();
        readyMode = 1;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, i, 1'b0);
            repeat (3) applyStimulus(1'b0, 0, 1'b0);
        end
        waitOutputs(framesFor(sent.size()) * FL, 500, "wrap");

        // Reset in the middle of a frame, then a fresh frame from new samples.
        resetDut();
        readyMode = 1;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 768 + i, 1'b0);
        polls = 0;
        while (outIdx < 3 && polls < 100) begin
            applyStimulus(1'b0, 0, 1'b0);
            polls++;
        end
        checkOutput("midReachIdx", outIdx, 3);
        checkOutput("midIdx3Data", m_data, 771);
        #2;
        reset = 1'b1;
        sent.delete();
        outIdx      = 0;
        holdPending = 1'b0;
        #1;
        checkOutput("midRstValid", m_valid, 0);
        checkOutput("midRstLast", m_last, 0);
        checkOutput("midRstOcc", occupancy, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1280 + i, 1'b0);
        waitOutputs(framesFor(sent.size()) * FL, 200, "postRst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/overlap_input_queue.md
OVERLAP_INPUT_QUEUE -- requirements
Module: overlap_input_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: ADC sample width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 1024: samples per emitted frame; power of 2, at least 4.
REQ-003 SHALL have parameter HOP, default 512: frame-to-frame advance; power of 2, between 1 and FRAME_LEN inclusive.
REQ-004 SHALL have parameter DEPTH, default 4096: buffer entries; power of 2, at least 2*FRAME_LEN.
REQ-005 SHALL have port clock, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port adc_sample, input, DATA_WIDTH bits: sampler data.
REQ-008 SHALL have port adc_valid, input, 1 bit: one-cycle strobe per sample.
REQ-009 SHALL have port overflow_clear, input, 1 bit: clears the sticky overflow flag.
REQ-010 SHALL have port m_data, output, DATA_WIDTH bits: AXI-Stream tdata.
REQ-011 SHALL have port m_valid, output, 1 bit: AXI-Stream tvalid.
REQ-012 SHALL have port m_ready, input, 1 bit: AXI-Stream tready.
REQ-013 SHALL have port m_last, output, 1 bit: high on the final sample of each frame.
REQ-014 SHALL have port overflow, output, 1 bit: sticky; set when a sample was dropped.
REQ-015 SHALL have port occupancy, output, log2(DEPTH)+1 bits: wr_ptr minus frame_start.

Function
REQ-016 SHALL write each accepted sample into a DEPTH-entry circular RAM at wr_ptr, then increment wr_ptr modulo DEPTH.
REQ-017 SHALL drop the sample when adc_valid is high and occupancy equals DEPTH, leaving wr_ptr unchanged and setting overflow on the next edge.
REQ-018 SHALL clear overflow on the edge after overflow_clear; if clear and a new drop occur in the same cycle, set wins.
REQ-019 SHALL use FSM states IDLE, PRIME, STREAM, ADVANCE.
REQ-020 SHALL move IDLE to PRIME when occupancy is at least FRAME_LEN; rd_ptr loads frame_start and idx loads 0.
REQ-021 SHALL, in PRIME, issue the synchronous RAM read (1-cycle latency) and fill the output stage; m_valid goes high exactly 2 cycles after leaving IDLE.
REQ-022 SHALL, in STREAM, hold m_data, m_valid and m_last stable while m_valid is high and m_ready is low (no data change, no sample loss).
REQ-023 SHALL use a 2-entry skid output stage so that a continuous m_ready gives one sample per cycle.
REQ-024 SHALL assert m_last with the sample at idx FRAME_LEN-1; the handshake on that sample moves the FSM to ADVANCE.
REQ-025 SHALL, in ADVANCE (one cycle), add HOP to frame_start modulo DEPTH, then return to IDLE, or go directly to PRIME when occupancy minus HOP is at least FRAME_LEN.
REQ-026 SHALL emit consecutive frames that overlap by FRAME_LEN-HOP samples; the sample at idx k of frame n comes from address (n*HOP+k) mod DEPTH.
REQ-027 SHALL compute occupancy with one extra bit; a write and a frame advance in the same cycle give occ+1-HOP.
REQ-028 SHALL wrap all pointer arithmetic modulo DEPTH with no special case at the address boundary.
REQ-029 SHALL keep writes active in every FSM state; the region [frame_start, frame_start+FRAME_LEN) is never overwritten because the DEPTH occupancy limit protects it.

Reset
REQ-030 SHALL, on reset (asynchronous at any point, including mid-frame), clear wr_ptr, frame_start, rd_ptr, idx and occupancy to 0, set the FSM to IDLE, and drive m_valid, m_last and overflow to 0.
REQ-031 SHALL leave m_data unspecified during reset and leave RAM contents unreset; the first frame after reset uses only post-reset samples.

Structure
REQ-032 SHALL place the FSM state enumeration and the clog2-based width constants in the shared package input_queue_pkg.
REQ-033 SHALL implement pointer, occupancy and FSM logic in the sub-module overlap_addr_gen; the RAM is an inferred simple dual-port array; the top level contains the skid stage.

Verification (bench parameters: DATA_WIDTH=12, FRAME_LEN=8, HOP=4, DEPTH=32)
REQ-034 SHALL cover: write samples 0..7 with m_ready=1 -> m_valid rises 2 cycles after the 8th write, data 0..7, m_last on 7.
REQ-035 SHALL cover: continuous ramp 0..19 with m_ready=1 -> frames 0-7, 4-11, 8-15, 12-19, each with m_last on its final sample.
REQ-036 SHALL cover: random m_ready at 30% duty -> data held while stalled; the frame sequence matches the full-ready run exactly.
REQ-037 SHALL cover: m_ready=0 while writing 33 samples -> occupancy saturates at 32, overflow=1, sample 32 dropped; overflow_clear then gives overflow=0.
REQ-038 SHALL cover: pointer wrap by streaming 100 samples -> the frame starting at 28 yields 28..31,32..35 from RAM addresses 28..31,0..3.
REQ-039 SHALL cover: reset asserted mid-STREAM at idx 3 -> m_valid=0 immediately; after release, the next frame starts with the first post-reset sample.
